// File: rtl/muldiv_unit_pkg.sv
// rtl/muldiv_unit_pkg.sv - shared op/state types and op decode for the multiply/divide unit
package muldiv_unit_pkg;

    typedef enum logic [2:0] {
        MULT  = 3'd0,
        MULTU = 3'd1,
        DIV   = 3'd2,
        DIVU  = 3'd3,
        MADD  = 3'd4,
        MADDU = 3'd5,
        MSUB  = 3'd6,
        MSUBU = 3'd7
    } muldiv_op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } muldiv_state_t;

    typedef struct packed {
        logic is_signed;
        logic is_div;
        logic is_acc;
        logic is_sub;
    } muldiv_dec_t;

    // Bit 0 of the op code is the unsigned suffix for every op.
    function automatic muldiv_dec_t muldiv_decode(input muldiv_op_t op);
        muldiv_dec_t d;
        d.is_signed = ~op[0];
        d.is_div    = (op == DIV) || (op == DIVU);
        d.is_acc    = op[2];
        d.is_sub    = op[2] & op[1];
        return d;
    endfunction

endpackage

// File: rtl/muldiv_unit_if.sv
// rtl/muldiv_unit_if.sv - request/result bundle between the execute stage and the multiply/divide unit
// master: requester (valid, op, a, b, acc_hi, acc_lo, flush out; ready, busy, done, hi, lo in)
// slave : muldiv_unit (directions reversed)
interface muldiv_unit_if #(parameter int WIDTH = 32) ();
    import muldiv_unit_pkg::*;

    logic             valid;
    muldiv_op_t       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] acc_hi;
    logic [WIDTH-1:0] acc_lo;
    logic             flush;
    logic             ready;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output valid, op, a, b, acc_hi, acc_lo, flush,
        input  ready, busy, done, hi, lo
    );

    modport slave (
        input  valid, op, a, b, acc_hi, acc_lo, flush,
        output ready, busy, done, hi, lo
    );
endinterface

// File: rtl/muldiv_unit_div_iter.sv
// rtl/muldiv_unit_div_iter.sv - unsigned radix-2 restoring divider, one quotient bit per cycle
// Ports: clk, resetn (async active-low), start_i (load operands), a_i dividend, b_i divisor,
//        done_o (high once all WIDTH iterations are complete), q_o quotient, r_o remainder.
module div_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             done_o,
    output logic [WIDTH-1:0] q_o,
    output logic [WIDTH-1:0] r_o
);
    localparam int CW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] dvs_q;
    logic [CW-1:0]    cnt_q;
    logic             run_q;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;

    // The dividend is shifted out of quo_q MSB-first while quotient bits enter at the LSB.
    always_comb begin
        shifted = {rem_q, quo_q[WIDTH-1]};
        diff    = shifted - {1'b0, dvs_q};
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rem_q <= '0;
            quo_q <= '0;
            dvs_q <= '0;
            cnt_q <= '0;
            run_q <= 1'b0;
        end else if (start_i) begin
            rem_q <= '0;
            quo_q <= a_i;
            dvs_q <= b_i;
            cnt_q <= CW'(WIDTH);
            run_q <= 1'b1;
        end else if (run_q) begin
            if (cnt_q != '0) begin
                // diff MSB set means the trial subtraction borrowed: restore.
                if (!diff[WIDTH]) begin
                    rem_q <= diff[WIDTH-1:0];
                    quo_q <= {quo_q[WIDTH-2:0], 1'b1};
                end else begin
                    rem_q <= shifted[WIDTH-1:0];
                    quo_q <= {quo_q[WIDTH-2:0], 1'b0};
                end
                cnt_q <= cnt_q - 1'b1;
            end else begin
                run_q <= 1'b0;
            end
        end
    end

    assign done_o = run_q && (cnt_q == '0);
    assign q_o    = quo_q;
    assign r_o    = rem_q;
endmodule

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - multi-cycle signed/unsigned multiply/divide unit with flush and optional accumulate
// Ports: clk, resetn (async active-low), bus (muldiv_unit_if.slave: valid/op/a/b/acc_hi/acc_lo/flush in,
//        ready/busy/done/hi/lo out). Parameters: WIDTH operand width, MUL_LAT multiply latency (>=1).
// Optional macro MULDIV_MADD_EN: MADD/MSUB ops accumulate into {acc_hi,acc_lo} with one extra cycle.
module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int MUL_LAT = 3
) (
    input  logic          clk,
    input  logic          resetn,
    muldiv_unit_if.slave  bus
);
    localparam int PW = 2 * WIDTH;
    localparam int CW = $clog2(MUL_LAT + 2);

    muldiv_state_t    state_q;
    logic             done_q;
    logic [WIDTH-1:0] hi_q, lo_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] mag_a_q, mag_b_q, raw_a_q;
    logic             neg_pq_q, neg_r_q, div0_q;

    muldiv_dec_t      dec_in;
    logic             ready, accept;
    logic [WIDTH-1:0] mag_a_d, mag_b_d;
    logic [PW-1:0]    prod_raw, prod_tail, mul_res_d, mul_fin_d;
    logic [CW-1:0]    mul_target;
    logic             div_done;
    logic [WIDTH-1:0] div_q, div_r, div_lo_d, div_hi_d;

    assign dec_in  = muldiv_decode(bus.op);
    assign ready   = (state_q == ST_IDLE) || (state_q == ST_DONE);
    assign accept  = bus.valid & ready & ~bus.flush;
    assign mag_a_d = (dec_in.is_signed & bus.a[WIDTH-1]) ? -bus.a : bus.a;
    assign mag_b_d = (dec_in.is_signed & bus.b[WIDTH-1]) ? -bus.b : bus.b;

    // Magnitude product from the captured operands, delayed so it lands on the MUL_LAT-th edge.
    assign prod_raw = PW'(mag_a_q) * PW'(mag_b_q);

    generate
        if (MUL_LAT > 1) begin : g_pipe
            logic [PW-1:0] pipe_q [MUL_LAT-1];
            always_ff @(posedge clk or negedge resetn) begin
                if (!resetn) begin
                    for (int i = 0; i < MUL_LAT - 1; i++) pipe_q[i] <= '0;
                end else begin
                    pipe_q[0] <= prod_raw;
                    for (int i = 1; i < MUL_LAT - 1; i++) pipe_q[i] <= pipe_q[i-1];
                end
            end
            assign prod_tail = pipe_q[MUL_LAT-2];
        end else begin : g_nopipe
            assign prod_tail = prod_raw;
        end
    endgenerate

    assign mul_res_d = neg_pq_q ? -prod_tail : prod_tail;

`ifdef MULDIV_MADD_EN
    logic [PW-1:0]    mul_res_q;
    logic [WIDTH-1:0] acc_hi_q, acc_lo_q;
    logic             acc_op_q, sub_op_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mul_res_q <= '0;
            acc_hi_q  <= '0;
            acc_lo_q  <= '0;
            acc_op_q  <= 1'b0;
            sub_op_q  <= 1'b0;
        end else begin
            mul_res_q <= mul_res_d;
            if (accept) begin
                acc_hi_q <= bus.acc_hi;
                acc_lo_q <= bus.acc_lo;
                acc_op_q <= dec_in.is_acc;
                sub_op_q <= dec_in.is_sub;
            end
        end
    end

    // The registered product gives the accumulate add its own cycle.
    assign mul_target = acc_op_q ? CW'(MUL_LAT + 1) : CW'(MUL_LAT);
    assign mul_fin_d  = !acc_op_q ? mul_res_d :
                        sub_op_q  ? ({acc_hi_q, acc_lo_q} - mul_res_q) :
                                    ({acc_hi_q, acc_lo_q} + mul_res_q);
`else
    logic unused_acc;
    assign unused_acc = ^{bus.acc_hi, bus.acc_lo, dec_in};
    assign mul_target = CW'(MUL_LAT);
    assign mul_fin_d  = mul_res_d;
`endif

    div_iter #(.WIDTH(WIDTH)) u_div (
        .clk     (clk),
        .resetn  (resetn),
        .start_i (accept & dec_in.is_div),
        .a_i     (mag_a_d),
        .b_i     (mag_b_d),
        .done_o  (div_done),
        .q_o     (div_q),
        .r_o     (div_r)
    );

    // Divide-by-zero bypasses the sign fix-up: quotient all ones, remainder the raw dividend.
    assign div_lo_d = div0_q ? '1      : (neg_pq_q ? -div_q : div_q);
    assign div_hi_d = div0_q ? raw_a_q : (neg_r_q  ? -div_r : div_r);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= ST_IDLE;
            done_q   <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            cnt_q    <= '0;
            mag_a_q  <= '0;
            mag_b_q  <= '0;
            raw_a_q  <= '0;
            neg_pq_q <= 1'b0;
            neg_r_q  <= 1'b0;
            div0_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (accept) begin
                mag_a_q  <= mag_a_d;
                mag_b_q  <= mag_b_d;
                raw_a_q  <= bus.a;
                neg_pq_q <= dec_in.is_signed & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                neg_r_q  <= dec_in.is_signed & bus.a[WIDTH-1];
                div0_q   <= (bus.b == '0);
            end
            if (bus.flush) begin
                state_q <= ST_IDLE;
            end else begin
                case (state_q)
                    ST_IDLE, ST_DONE: begin
                        if (accept) begin
                            state_q <= dec_in.is_div ? ST_DIV : ST_MUL;
                            cnt_q   <= CW'(1);
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end
                    ST_MUL: begin
                        if (cnt_q == mul_target) begin
                            state_q      <= ST_DONE;
                            done_q       <= 1'b1;
                            {hi_q, lo_q} <= mul_fin_d;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    ST_DIV: begin
                        if (div_done) begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                            hi_q    <= div_hi_d;
                            lo_q    <= div_lo_d;
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign bus.ready = ready;
    assign bus.busy  = bus.valid & ~done_q;
    assign bus.done  = done_q;
    assign bus.hi    = hi_q;
    assign bus.lo    = lo_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - scoreboard bench for muldiv_unit with directed vectors
module tb_muldiv_unit;
    import muldiv_unit_pkg::*;

    localparam int W    = 32;
    localparam int LAT  = 3;
    localparam int DLAT = W + 1;
`ifdef MULDIV_MADD_EN
    localparam int          ALAT      = LAT + 1;
    localparam logic [31:0] MADD_LO   = 32'h0000_0016;
    localparam logic [31:0] MSUBU_HI  = 32'hFFFF_FFFF;
    localparam logic [31:0] MSUBU_LO  = 32'hFFFF_FFFF;
    localparam logic [31:0] MSUB_HI   = 32'h0000_0000;
    localparam logic [31:0] MSUB_LO   = 32'h0000_0007;
`else
    localparam int          ALAT      = LAT;
    localparam logic [31:0] MADD_LO   = 32'h0000_000C;
    localparam logic [31:0] MSUBU_HI  = 32'h0000_0000;
    localparam logic [31:0] MSUBU_LO  = 32'h0000_0001;
    localparam logic [31:0] MSUB_HI   = 32'hFFFF_FFFF;
    localparam logic [31:0] MSUB_LO   = 32'hFFFF_FFFE;
`endif

    logic clk = 1'b0;
    logic resetn = 1'b0;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    muldiv_unit_if #(.WIDTH(W)) bus ();

    muldiv_unit #(.WIDTH(W), .MUL_LAT(LAT)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        int           cyc;
        string        name;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    // Monitor: every done strobe must match the oldest outstanding expectation.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (resetn && bus.done) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done: got done=1 at cycle %0d, expected no completion", cyc);
            end else begin
                e = sb.pop_front();
                check({e.name, "_hi"}, 64'(bus.hi), 64'(e.hi));
                check({e.name, "_lo"}, 64'(bus.lo), 64'(e.lo));
                check({e.name, "_cycle"}, 64'(cyc), 64'(e.cyc));
            end
        end
    end

    task automatic scramble_inputs();
        bus.a      = $urandom;
        bus.b      = $urandom;
        bus.acc_hi = $urandom;
        bus.acc_lo = $urandom;
        bus.op     = muldiv_op_t'($urandom_range(0, 7));
    endtask

    // Called on a falling edge; returns on the falling edge of the done cycle with valid still high.
    task automatic issue(input muldiv_op_t op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] ahi, input logic [W-1:0] alo,
                         input logic [W-1:0] ehi, input logic [W-1:0] elo,
                         input int lat, input string name);
        int   n;
        exp_t e;
        bus.op = op; bus.a = a; bus.b = b; bus.acc_hi = ahi; bus.acc_lo = alo;
        bus.valid = 1'b1;
        n = 0;
        while (!bus.ready && n < 100) begin @(negedge clk); n++; end
        if (!bus.ready) begin
            checks++; failures++;
            $display("FAIL %s_ready_timeout: got ready=0, expected 1 within 100 cycles", name);
            bus.valid = 1'b0;
            return;
        end
        e.hi = ehi; e.lo = elo; e.cyc = cyc + 1 + lat; e.name = name;
        sb.push_back(e);
        @(posedge clk);
        @(negedge clk);
        scramble_inputs();
        if (lat > 1) check({name, "_busy"}, 64'(bus.busy), 64'd1);
        n = 0;
        while (!bus.done && n < 200) begin @(negedge clk); n++; end
        if (!bus.done) begin
            checks++; failures++;
            $display("FAIL %s_done_timeout: got done=0, expected done within 200 cycles", name);
        end
    endtask

    task automatic idle();
        bus.valid = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        bus.valid = 1'b0; bus.flush = 1'b0; bus.op = MULT;
        bus.a = '0; bus.b = '0; bus.acc_hi = '0; bus.acc_lo = '0;
        resetn = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_ready", 64'(bus.ready), 64'd1);
        check("reset_done",  64'(bus.done),  64'd0);
        check("reset_busy",  64'(bus.busy),  64'd0);
        check("reset_hi",    64'(bus.hi),    64'd0);
        check("reset_lo",    64'(bus.lo),    64'd0);
        resetn = 1'b1;
        @(negedge clk);

        issue(MULT, 32'hFFFF_FFFD, 32'd5, 0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFF1, LAT, "mult_neg3x5");
        idle();
        issue(DIVU, 32'd100, 32'd7, 0, 0, 32'd2, 32'h0000_000E, DLAT, "divu_100_7");
        issue(DIV, 32'hFFFF_FFF9, 32'd2, 0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFD, DLAT, "div_m7_2");
        idle();
        issue(DIV, 32'h1234_5678, 32'd0, 0, 0, 32'h1234_5678, 32'hFFFF_FFFF, DLAT, "div_by_zero");
        issue(DIV, 32'hFFFF_FF00, 32'd0, 0, 0, 32'hFFFF_FF00, 32'hFFFF_FFFF, DLAT, "div_neg_by_zero");
        issue(DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 32'd0, 32'h8000_0000, DLAT, "div_min_m1");
        issue(DIV, 32'd7, 32'hFFFF_FFFE, 0, 0, 32'd1, 32'hFFFF_FFFD, DLAT, "div_7_m2");
        idle();

        // Flush ten cycles into a divide: no completion, results untouched.
        bus.op = DIVU; bus.a = 32'd1000; bus.b = 32'd3; bus.valid = 1'b1;
        @(negedge clk);
        bus.valid = 1'b0;
        repeat (9) @(negedge clk);
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        check("flush_ready", 64'(bus.ready), 64'd1);
        check("flush_done",  64'(bus.done),  64'd0);
        check("flush_hi",    64'(bus.hi),    64'd1);
        check("flush_lo",    64'(bus.lo),    64'(32'hFFFF_FFFD));
        repeat (40) @(negedge clk);

        // Flush together with valid in IDLE must not accept.
        bus.op = MULT; bus.a = 32'd2; bus.b = 32'd2; bus.valid = 1'b1; bus.flush = 1'b1;
        @(negedge clk);
        bus.valid = 1'b0; bus.flush = 1'b0;
        check("flush_valid_ready", 64'(bus.ready), 64'd1);
        repeat (8) @(negedge clk);
        check("flush_valid_lo", 64'(bus.lo), 64'(32'hFFFF_FFFD));

        issue(MULTU, 32'd2, 32'd3, 0, 0, 32'd0, 32'd6, LAT, "b2b_first");
        issue(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 32'hFFFF_FFFE, 32'h0000_0001, LAT, "b2b_second");
        issue(MULT, 32'h8000_0000, 32'h8000_0000, 0, 0, 32'h4000_0000, 32'd0, LAT, "mult_min_min");
        idle();
        issue(MADD, 32'd3, 32'd4, 32'd0, 32'h0000_000A, 32'd0, MADD_LO, ALAT, "madd_3x4");
        issue(MSUBU, 32'd1, 32'd1, 32'd0, 32'd0, MSUBU_HI, MSUBU_LO, ALAT, "msubu_1x1");
        issue(MSUB, 32'hFFFF_FFFF, 32'd2, 32'd0, 32'd5, MSUB_HI, MSUB_LO, ALAT, "msub_m1x2");
        idle();

        // Reset in the middle of a divide aborts it without a completion.
        bus.op = DIV; bus.a = 32'd50; bus.b = 32'd3; bus.valid = 1'b1;
        @(negedge clk);
        bus.valid = 1'b0;
        repeat (5) @(negedge clk);
        resetn = 1'b0;
        #1;
        check("midreset_ready", 64'(bus.ready), 64'd1);
        check("midreset_done",  64'(bus.done),  64'd0);
        check("midreset_hi",    64'(bus.hi),    64'd0);
        check("midreset_lo",    64'(bus.lo),    64'd0);
        @(negedge clk);
        resetn = 1'b1;
        repeat (40) @(negedge clk);

        check("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Parametrised multi-cycle multiply/divide unit for the execute stage; successor to the fixed 32-bit mult/div pair.
- Handles signed/unsigned multiply and divide internally: operand absolute value, result negation and remainder sign fix-up.
- Produces the HI/LO result; its busy indication drives the front-end stall.
- Adds a flush (exception cancel), configurable width and multiply latency, back-to-back issue, and optional multiply-accumulate.

Parameters:
- WIDTH, 32: operand width; the product is 2*WIDTH bits.
- MUL_LAT, 3: multiply latency in cycles, >=1; implemented as a pipelined/registered product.

Ports:
- clk  in  1  clock
- resetn  in  1  reset; asynchronous, active-low
- valid  in  1  request present
- op  in  3  muldiv_op_t: MULT, MULTU, DIV, DIVU, MADD, MADDU, MSUB, MSUBU
- a  in  WIDTH  rs operand (dividend for DIV/DIVU)
- b  in  WIDTH  rt operand (divisor for DIV/DIVU)
- acc_hi  in  WIDTH  current HI, accumulate ops only
- acc_lo  in  WIDTH  current LO, accumulate ops only
- flush  in  1  cancel any in-flight operation
- ready  out  1  unit can accept this cycle
- busy  out  1  = valid & ~done; stall request to the pipeline
- done  out  1  one-cycle result strobe
- hi  out  WIDTH  product[2W-1:W] or remainder
- lo  out  WIDTH  product[W-1:0] or quotient

Behaviour:
- Reset: state IDLE; ready=1, done=0, hi=0, lo=0, counters cleared. Reset asserted mid-operation aborts the operation with no done.
- States: IDLE, MUL, DIV, DONE.
- ready = (state==IDLE)|(state==DONE).
- Accept: at the rising edge where valid & ready & ~flush.
- Transitions:
  - IDLE/DONE: on accept, go to MUL or DIV; otherwise go to IDLE.
  - MUL: after MUL_LAT cycles, go to DONE.
  - DIV: after WIDTH+1 cycles (WIDTH radix-2 restoring iterations plus 1 sign fix-up cycle), go to DONE.
  - DONE: done=1 for exactly one cycle; hi/lo are updated on the edge entering DONE.
- Latency: done is high in the cycle MUL_LAT cycles after the accepting edge for MUL ops, and WIDTH+1 cycles after it for DIV ops.
- Result hold: hi/lo stay stable from DONE until the next completion. Back-to-back accept in DONE is legal and costs zero bubble.
- Signed ops: operate on magnitudes.
  - Product is negated iff a[W-1]^b[W-1].
  - Quotient is negated iff the signs differ.
  - Remainder takes the sign of the dividend.
- Divide by zero (b==0), signed or unsigned: lo = all ones, hi = a. Latency is unchanged; no exception is raised.
- Signed MIN / -1: lo = MIN, hi = 0; no trap.
- Operands a, b, op and acc are captured at accept. Later changes on the inputs are ignored.
- Flush: synchronous.
  - Next state is IDLE; no done is generated; hi/lo keep their previous values.
  - Flush wins over a simultaneous accept, and over completion in the same cycle.
- valid while not ready is ignored; the requester must hold valid until done.
- Without MULDIV_MADD_EN, MADD/MADDU/MSUB/MSUBU behave as MULT/MULTU and acc_* is ignored.

Optional Feature:
- Macro MULDIV_MADD_EN.
- Defined:
  - MADD(U) gives {hi,lo} = {acc_hi,acc_lo} + product.
  - MSUB(U) gives {hi,lo} = {acc_hi,acc_lo} - product.
  - Arithmetic is 2*WIDTH-bit modular; signedness follows the op suffix for the product only.
  - Accumulate adds exactly 1 cycle: latency is MUL_LAT+1.
- Undefined: accumulate ops alias to plain multiply (latency MUL_LAT); acc_hi/acc_lo are unused.

Decomposition:
- The shared pipeline package holds:
  - muldiv_op_t enum (3 bits);
  - muldiv_state_t enum;
  - an is_signed/is_div/is_acc decode function.
- Sub-module div_iter(WIDTH) holds the restoring divider datapath and iteration counter (start, a, b, done, q, r, unsigned).
- muldiv_unit owns sign handling, the FSM, the multiply pipeline and flush.

Test Plan:
- MULT a=FFFFFFFD(-3), b=5, WIDTH=32, MUL_LAT=3 -> done 3 cycles after accept; hi=FFFFFFFF, lo=FFFFFFF1.
- DIVU a=100, b=7 -> done 33 cycles after accept; lo=0000000E, hi=00000002. Then DIV a=FFFFFFF9(-7), b=2 -> lo=FFFFFFFD, hi=FFFFFFFF.
- DIV a=12345678, b=0 -> lo=FFFFFFFF, hi=12345678 after 33 cycles. DIV a=80000000, b=FFFFFFFF -> lo=80000000, hi=0.
- DIVU issued, flush pulsed 10 cycles later -> no done, ready=1 next cycle, hi/lo unchanged. Flush coincident with valid in IDLE -> not accepted.
- Back-to-back: MULTU 2*3 then accept MULTU FFFFFFFF*FFFFFFFF in the done cycle -> lo=6, then hi=FFFFFFFE, lo=00000001 exactly 3 cycles later. resetn dropped mid-DIV -> all outputs 0, ready=1.
- MULDIV_MADD_EN: acc={0,0000000A}, MADD 3*4 -> lo=00000016 at MUL_LAT+1. MSUBU acc={0,0}, 1*1 -> hi=lo=FFFFFFFF. Without macro, MADD 3*4 -> lo=0000000C at MUL_LAT.
